// File: rtl/lab1_imul_pkg.sv
// Shared types for the imul dot-product slice: FSM state encoding and
// the field layout of the {ovf, sum} result word.
package lab1_imul_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int OVF_BIT = 32;
    localparam int SUM_MSB = 31;

endpackage

// File: rtl/lab1_imul_dot_accum_dpath.sv
// Accumulator datapath: 32-bit wrap-around sum, sticky carry-out flag, term down-counter.
// Latency: acc/ovf/cnt update one cycle after an enable; no internal storage beyond that.
// Backpressure: none here; the control only asserts acc_en on an accepted product.
module lab1_imul_dot_accum_dpath
    import lab1_imul_pkg::*;
#(
    parameter int p_cnt_nbits = 8
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   acc_clr,
    input  logic                   acc_en,
    input  logic                   cnt_load,
    input  logic [p_cnt_nbits-1:0] cfg_msg,
    input  logic [SUM_MSB:0]       in_msg,
    output logic [SUM_MSB:0]       acc,
    output logic                   ovf,
    output logic                   cnt_is_one
);

    logic [p_cnt_nbits-1:0] cnt;
    logic [SUM_MSB+1:0]     sum;

    // Extra top bit captures the carry out of bit 31 for the sticky flag.
    assign sum        = {1'b0, acc} + {1'b0, in_msg};
    assign cnt_is_one = (cnt == p_cnt_nbits'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (acc_clr) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (acc_en) begin
            acc <= sum[SUM_MSB:0];
            ovf <= ovf | sum[SUM_MSB+1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt_load) begin
            cnt <= cfg_msg;
        end else if (acc_en) begin
            cnt <= cnt - p_cnt_nbits'(1);
        end
    end

endmodule

// File: rtl/lab1_imul_dot_accum.sv
// Sums N consecutive multiplier products and returns {ovf, sum}; N arrives on the cfg port.
// Latency: out_val rises the cycle after the N-th product (or after cfg when N=0).
// Backpressure: in_rdy only in ACCUM; DONE holds out_msg until out_rdy; cfg waits for IDLE.
module lab1_imul_dot_accum
    import lab1_imul_pkg::*;
#(
    parameter int p_cnt_nbits = 8
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_val,
    output logic                   cfg_rdy,
    input  logic [p_cnt_nbits-1:0] cfg_msg,
    input  logic                   in_val,
    output logic                   in_rdy,
    input  logic [SUM_MSB:0]       in_msg,
    output logic                   out_val,
    input  logic                   out_rdy,
    output logic [OVF_BIT:0]       out_msg
);

    state_t          state, state_nxt;
    logic            acc_clr, acc_en, cnt_load, cnt_is_one;
    logic [SUM_MSB:0] acc;
    logic            ovf;

    // Handshake outputs depend only on the state register (and reset gating).
    assign cfg_rdy = !reset && (state == IDLE);
    assign in_rdy  = !reset && (state == ACCUM);
    assign out_val = !reset && (state == DONE);
    assign out_msg = {ovf, acc};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        cnt_load  = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_val) begin
                    acc_clr = 1'b1;
                    if (cfg_msg != '0) begin
                        cnt_load  = 1'b1;
                        state_nxt = ACCUM;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            ACCUM: begin
                if (in_val) begin
                    acc_en = 1'b1;
                    if (cnt_is_one) state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_rdy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    lab1_imul_dot_accum_dpath #(
        .p_cnt_nbits (p_cnt_nbits)
    ) u_dpath (
        .clk        (clk),
        .reset      (reset),
        .acc_clr    (acc_clr),
        .acc_en     (acc_en),
        .cnt_load   (cnt_load),
        .cfg_msg    (cfg_msg),
        .in_msg     (in_msg),
        .acc        (acc),
        .ovf        (ovf),
        .cnt_is_one (cnt_is_one)
    );

endmodule

// File: tb/tb_lab1_imul_dot_accum.sv
// Directed bench for the dot-product accumulator: inputs driven and outputs
// sampled on the falling edge, so every posedge sees stable handshakes.
module tb_lab1_imul_dot_accum;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_val;
    logic        cfg_rdy;
    logic [7:0]  cfg_msg;
    logic        in_val;
    logic        in_rdy;
    logic [31:0] in_msg;
    logic        out_val;
    logic        out_rdy;
    logic [32:0] out_msg;

    int passed = 0;
    int total  = 0;
    int fire_cnt = 0;
    bit trace_en = 1'b0;

    always #5 clk = ~clk;

    lab1_imul_dot_accum #(.p_cnt_nbits(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .cfg_val (cfg_val),
        .cfg_rdy (cfg_rdy),
        .cfg_msg (cfg_msg),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .in_msg  (in_msg),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .out_msg (out_msg)
    );

    always @(posedge clk) if (in_val && in_rdy) fire_cnt++;

    function automatic string line_trace();
        string st;
        st = cfg_rdy ? "I" : (in_rdy ? "A" : (out_val ? "D" : "-"));
        return $sformatf("%b%b:%02h | %b%b:%08h | %b%b:%09h | %s acc=%08h cnt=%02h",
                         cfg_val, cfg_rdy, cfg_msg, in_val, in_rdy, in_msg,
                         out_val, out_rdy, out_msg, st,
                         dut.u_dpath.acc, dut.u_dpath.cnt);
    endfunction

    always @(negedge clk) if (trace_en) $display("%s", line_trace());

    // ---------------- drive helpers (no checking besides timeouts) ----------
    task automatic send_cfg(input logic [7:0] n);
        int b = 0;
        cfg_msg = n;
        cfg_val = 1'b1;
        while (!cfg_rdy && b < 50) begin @(negedge clk); b++; end
        if (!cfg_rdy) begin
            total++;
            $display("FAIL cfg_timeout: cfg_rdy=%b required 1", cfg_rdy);
        end
        @(negedge clk);
        cfg_val = 1'b0;
        cfg_msg = 8'hEE;
    endtask

    task automatic send_in(input logic [31:0] v, input int gap);
        int b = 0;
        in_val = 1'b0;
        repeat (gap) @(negedge clk);
        in_msg = v;
        in_val = 1'b1;
        while (!in_rdy && b < 50) begin @(negedge clk); b++; end
        if (!in_rdy) begin
            total++;
            $display("FAIL in_timeout: in_rdy=%b required 1", in_rdy);
        end
        @(negedge clk);
        in_val = 1'b0;
    endtask

    task automatic wait_out();
        int b = 0;
        while (!out_val && b < 50) begin @(negedge clk); b++; end
        if (!out_val) begin
            total++;
            $display("FAIL out_timeout: out_val=%b required 1", out_val);
        end
    endtask

    task automatic take_out();
        out_rdy = 1'b1;
        @(negedge clk);
        out_rdy = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; cfg_val = 0; cfg_msg = 0; in_val = 0; in_msg = 0; out_rdy = 0;
        repeat (2) @(negedge clk);
        total++; if ({cfg_rdy, in_rdy, out_val} !== 3'b000) $display("FAIL reset_handshake: got %b required 000", {cfg_rdy, in_rdy, out_val}); else passed++;
        total++; if (out_msg !== 33'h0) $display("FAIL reset_msg: got %h required 0", out_msg); else passed++;
        reset = 1'b0;
        #1;
        total++; if (cfg_rdy !== 1'b1) $display("FAIL reset_release_cfg_rdy: got %b required 1", cfg_rdy); else passed++;
        total++; if ({in_rdy, out_val} !== 2'b00) $display("FAIL reset_release_idle: got %b required 00", {in_rdy, out_val}); else passed++;
        @(negedge clk);
    endtask

    task automatic test_basic();
        trace_en = 1'b1;
        send_cfg(8'd3);
        total++; if ({cfg_rdy, in_rdy} !== 2'b01) $display("FAIL basic_accum_state: got %b required 01", {cfg_rdy, in_rdy}); else passed++;
        send_in(32'd6, 0);
        send_in(32'd35, 0);
        total++; if (out_val !== 1'b0) $display("FAIL basic_early_out: got %b required 0", out_val); else passed++;
        send_in(32'h10, 0);
        total++; if (out_val !== 1'b1) $display("FAIL basic_out_latency: got %b required 1", out_val); else passed++;
        total++; if (out_msg !== 33'h0_00000039) $display("FAIL basic_sum: got %h required 000000039", out_msg); else passed++;
        total++; if ({cfg_rdy, in_rdy} !== 2'b00) $display("FAIL basic_done_rdys: got %b required 00", {cfg_rdy, in_rdy}); else passed++;
        take_out();
        total++; if ({cfg_rdy, out_val} !== 2'b10) $display("FAIL basic_back_idle: got %b required 10", {cfg_rdy, out_val}); else passed++;
        trace_en = 1'b0;
    endtask

    task automatic test_zero();
        send_cfg(8'd0);
        total++; if (out_val !== 1'b1) $display("FAIL zero_out_latency: got %b required 1", out_val); else passed++;
        total++; if (in_rdy !== 1'b0) $display("FAIL zero_in_rdy: got %b required 0", in_rdy); else passed++;
        total++; if (out_msg !== 33'h0) $display("FAIL zero_sum: got %h required 0", out_msg); else passed++;
        take_out();
        total++; if (cfg_rdy !== 1'b1) $display("FAIL zero_back_idle: got %b required 1", cfg_rdy); else passed++;
    endtask

    task automatic test_ovf();
        send_cfg(8'd2);
        send_in(32'hFFFF_FFFF, 0);
        send_in(32'h0000_0002, 0);
        wait_out();
        total++; if (out_msg !== {1'b1, 32'h0000_0001}) $display("FAIL ovf_set: got %h required 100000001", out_msg); else passed++;
        take_out();
        send_cfg(8'd1);
        send_in(32'd5, 0);
        wait_out();
        total++; if (out_msg !== {1'b0, 32'd5}) $display("FAIL ovf_clear: got %h required 000000005", out_msg); else passed++;
        take_out();
    endtask

    task automatic test_back_to_back();
        int f0;
        send_cfg(8'd4);
        f0 = fire_cnt;
        for (int i = 1; i <= 4; i++) send_in(32'(i), int'($urandom_range(0, 3)));
        wait_out();
        total++; if (fire_cnt - f0 !== 4) $display("FAIL stall_fire_count: got %0d required 4", fire_cnt - f0); else passed++;
        total++; if (out_msg !== 33'h0_0000000A) $display("FAIL stall_sum: got %h required 00000000a", out_msg); else passed++;
        // Output backpressure with a cfg waiting behind it.
        cfg_msg = 8'd9;
        cfg_val = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (out_msg !== 33'h0_0000000A || out_val !== 1'b1) $display("FAIL hold_msg[%0d]: got %b/%h required 1/00000000a", i, out_val, out_msg); else passed++;
            total++; if (cfg_rdy !== 1'b0) $display("FAIL hold_cfg_rdy[%0d]: got %b required 0", i, cfg_rdy); else passed++;
        end
        cfg_val = 1'b0;
        take_out();
    endtask

    task automatic test_reset_mid();
        send_cfg(8'd4);
        send_in(32'd100, 0);
        send_in(32'd200, 0);
        in_val = 1'b1; in_msg = 32'd300;
        reset = 1'b1;
        #1;
        total++; if ({cfg_rdy, in_rdy, out_val} !== 3'b000) $display("FAIL rstmid_handshake: got %b required 000", {cfg_rdy, in_rdy, out_val}); else passed++;
        total++; if (out_msg !== 33'h0) $display("FAIL rstmid_msg: got %h required 0", out_msg); else passed++;
        in_val = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++; if ({cfg_rdy, in_rdy, out_val} !== 3'b100) $display("FAIL rstmid_idle: got %b required 100", {cfg_rdy, in_rdy, out_val}); else passed++;
        total++; if (out_msg !== 33'h0) $display("FAIL rstmid_acc: got %h required 0", out_msg); else passed++;
        @(negedge clk);
        send_cfg(8'd1);
        send_in(32'd7, 0);
        wait_out();
        total++; if (out_msg !== {1'b0, 32'd7}) $display("FAIL rstmid_next: got %h required 000000007", out_msg); else passed++;
        take_out();
    endtask

    task automatic test_e2e();
        // Products of (3,4), (5,6), (-1,2) as a 32-bit multiplier returns them.
        send_cfg(8'd3);
        send_in(32'd12, 0);
        send_in(32'd30, 0);
        send_in(32'hFFFF_FFFE, 0);
        wait_out();
        total++; if (out_msg !== {1'b1, 32'h0000_0028}) $display("FAIL e2e_sum: got %h required 100000028", out_msg); else passed++;
        take_out();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_ovf();
        test_back_to_back();
        test_reset_mid();
        test_e2e();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/lab1_imul_dot_accum.md
# lab1_imul_dot_accum

Downstream companion to the iterative integer multiplier. It consumes the multiplier's 32-bit product stream over a val/rdy interface, sums a runtime-configured number of consecutive products, and emits one 32-bit sum plus a sticky overflow flag. Together the two blocks form a dot-product unit: the multiplier's resp port connects directly to this block's in port.

## Interface
- p_cnt_nbits, 8: width of the term-count field; a transaction covers at most 2^p_cnt_nbits−1 terms.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cfg_val  in  1  term-count request valid.
- cfg_rdy  out  1  block can accept a term count.
- cfg_msg  in  p_cnt_nbits  number of products N to sum.
- in_val  in  1  product valid (from the multiplier's resp_val).
- in_rdy  out  1  block accepts a product (to the multiplier's resp_rdy).
- in_msg  in  32  product.
- out_val  out  1  result valid.
- out_rdy  in  1  consumer accepts the result.
- out_msg  out  33  {ovf, sum[31:0]}.

## Operation
- A transfer fires on a cycle where val and rdy are both high at the rising edge.
- The FSM has three states: IDLE, ACCUM and DONE.
- **IDLE:** cfg_rdy=1; in_rdy=0; out_val=0.
  - cfg fire with N≠0: acc←0, ovf←0, cnt←N, go to ACCUM.
  - cfg fire with N=0: acc←0, ovf←0, go to DONE.
- **ACCUM:** in_rdy=1; cfg_rdy=0; out_val=0.
  - in fire: acc←acc+in_msg (mod 2^32), ovf←ovf|carry_out, cnt←cnt−1.
  - If the fire happens with cnt==1, go to DONE.
- **DONE:** out_val=1; out_msg={ovf, acc}; cfg_rdy=0; in_rdy=0.
  - out fire: go to IDLE. acc, ovf and cnt hold their values.
- Arithmetic is unsigned 32-bit wrap-around. ovf is set if any partial sum carried out of bit 31.
- In ACCUM, in_val low stalls the block with all state held; there is no timeout.
- In DONE, out_rdy low holds out_msg stable until the out fire.
- cfg_msg is sampled only on a cfg fire. Changes to it at any other time are ignored.

## Timing
- Reset, asynchronous: state=IDLE, acc=0, ovf=0, cnt=0.
  - While reset is high, every rdy/val output is 0 (gated by !reset) and out_msg=0.
  - cfg_rdy rises in the first cycle after reset deasserts.
  - Reset during ACCUM or DONE abandons the transaction; no partial result is ever emitted.
- All rdy/val outputs decode from registered state only. There is no combinational path from any input val/rdy to any output.
- out_msg comes directly from registers.
- Throughput in ACCUM is one product per cycle when in_val is held high.
- Latency:
  - out_val rises the cycle after the N-th in fire, or the cycle after the cfg fire when N=0.
  - cfg_rdy rises the cycle after the out fire.
  - A minimum transaction (N=1) therefore takes cfg fire → in fire → out fire → IDLE, with each step at least one cycle.
- cnt underflow is impossible: the DONE transition is taken on cnt==1, and cnt==0 never occurs in ACCUM.
- The block does not bypass states. A cfg presented in DONE waits until IDLE.

## Structure
- A shared package, lab1_imul_pkg, holds:
  - the state typedef (enum logic [1:0]: IDLE, ACCUM, DONE);
  - the out_msg field positions (OVF_BIT=32, SUM_MSB=31).
- Split the block into control (FSM, rdy/val decode) and a datapath sub-module, lab1_imul_dot_accum_dpath.
- The datapath holds:
  - the acc register: 32-bit, async-reset, enabled;
  - the ovf register: sticky, async-reset;
  - the cnt down-counter;
  - the 33-bit adder.
- The datapath exports one status signal: cnt_is_one.
- The control drives acc_clr, acc_en and cnt_load.
- Line trace shows cfg, in and out val/rdy/msg, the state letter (I/A/D), acc and cnt.

## Test plan
- N=3, products 6, 35, 0x10 with in_val held high → out_msg=0x0_00000039. out_val rises the cycle after the 3rd fire. cfg_rdy rises the cycle after the out fire.
- N=0 → out_val one cycle after the cfg fire, out_msg=0x0_00000000. in_rdy is never high.
- N=2, products 0xFFFFFFFF, 0x00000002 → out_msg={1, 0x00000001}. The next transaction (N=1, product 5) returns {0, 5}, confirming the ovf clear.
- Back-pressure and stall:
  - Random in_val gaps with N=4, products 1..4 → sum 0xA, with no products lost or duplicated.
  - out_rdy held low for 5 cycles → out_msg stable and cfg_rdy low throughout.
- Reset mid-ACCUM, after 2 of 4 products → all rdy/val outputs go to 0 immediately. After release the block is IDLE with acc=0. A new transaction (N=1, product 7) returns 7.
- End-to-end with the multiplier: pairs (3,4), (5,6), (−1,2) fed as 64-bit requests, N=3 → sum 0x00000028 with ovf=1, since 0xFFFFFFFE causes a carry.
